clock_set_ctrl: RTL and testbench

- Sequencing controller for an MM:SS time-of-day chain built from four cascaded digit counters with Load, Enable and terminal-count (TCO) pins:
  - digit 0: seconds units, mod-10
  - digit 1: seconds tens, mod-6
  - digit 2: minutes units, mod-10
  - digit 3: minutes tens, mod-6
- Generates per-digit Enable/Load from a 1 Hz tick in run mode, or from the Mode/Inc/Clr buttons in set mode.
- Produces display blanking for the field being set, and a carry pulse for a downstream hours stage.

---
 rtl/clock_set_ctrl.sv | 139 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Sequencing controller for an MM:SS digit-counter chain: run-mode carry cascade,
// button-driven minute/second setting, field blinking and hours carry.
module clock_set_ctrl #(
  parameter int unsigned PRESET_SU = 0,
  parameter int unsigned PRESET_ST = 0,
  parameter int unsigned PRESET_MU = 0,
  parameter int unsigned PRESET_MT = 0,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Tick,
  input  logic        BtnMode,
  input  logic        BtnInc,
  input  logic        BtnClr,
  input  logic [3:0]  Tco,
  output logic [3:0]  En,
  output logic [3:0]  Load,
  output logic [15:0] Valor,
  output logic [3:0]  Blank,
  output logic [1:0]  Mode,
  output logic        CarryOut
);

  localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned NBTN    = 3;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_ph;
  logic [NBTN-1:0]     btn_s;
  logic [NBTN-1:0]     btn_p;
  logic [NBTN-1:0]     press;
  logic                mode_press;
  logic                inc_press;
  logic                clr_press;
  logic                entering;

  // Button sync/edge registers; reset to 1 so a button held through reset is not a press.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      btn_s <= '1;
      btn_p <= '1;
    end else begin
      btn_s <= {BtnClr, BtnInc, BtnMode};
      btn_p <= btn_s;
    end
  end

  assign press      = btn_s & ~btn_p;
  assign mode_press = press[0];
  // A mode press swallows any inc/clr press arriving in the same cycle.
  assign inc_press  = press[1] & ~press[0];
  assign clr_press  = press[2] & ~press[0];

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mode_press) state_nxt = SET_MIN;
      SET_MIN: if (mode_press) state_nxt = SET_SEC;
      SET_SEC: if (mode_press) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign entering = (state_nxt != state);

  // State register and blink divider; divider restarts on every state entry, idles in RUN.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= RUN;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (entering || state_nxt == RUN) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Counter strobes are combinational so they land in the same cycle as tick or press.
  always_comb begin
    En       = '0;
    Load     = '0;
    CarryOut = 1'b0;
    if (!Rst) begin
      case (state)
        RUN: begin
          En[0]    = Tick;
          En[1]    = Tick & Tco[0];
          En[2]    = Tick & Tco[0] & Tco[1];
          En[3]    = Tick & Tco[0] & Tco[1] & Tco[2];
          CarryOut = Tick & (&Tco);
        end
        SET_MIN: begin
          if (clr_press) begin
            Load[3:2] = 2'b11;
          end else if (inc_press) begin
            En[2] = 1'b1;
            En[3] = Tco[2];
          end
        end
        SET_SEC: begin
          if (clr_press) begin
            Load[1:0] = 2'b11;
          end else if (inc_press) begin
            En[0] = 1'b1;
            En[1] = Tco[0];
          end
        end
        default: begin
          En       = '0;
          Load     = '0;
          CarryOut = 1'b0;
        end
      endcase
    end
  end

  assign Blank[3:2] = (state == SET_MIN) ? {2{blink_ph}} : 2'b00;
  assign Blank[1:0] = (state == SET_SEC) ? {2{blink_ph}} : 2'b00;
  assign Mode       = state;
  assign Valor      = {4'(PRESET_MT), 4'(PRESET_MU), 4'(PRESET_ST), 4'(PRESET_SU)};

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a behavioural MM:SS digit-counter chain
// and a queue of expected output vectors.
module tb_clock_set_ctrl;

  localparam int unsigned PMT = 1;
  localparam int unsigned PMU = 2;
  localparam logic [14:0] M_ALL  = 15'h7fff;
  localparam logic [14:0] M_NOBL = 15'h7ff0;
  localparam logic [14:0] M_MODE = 15'h0030;
  localparam logic [14:0] M_STRB = 15'h7fc0;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Tick;
  logic        BtnMode;
  logic        BtnInc;
  logic        BtnClr;
  logic [3:0]  Tco;
  logic [3:0]  En;
  logic [3:0]  Load;
  logic [15:0] Valor;
  logic [3:0]  Blank;
  logic [1:0]  Mode;
  logic        CarryOut;

  int n_assert = 0;
  int n_fail   = 0;

  string       tag_q[$];
  logic [14:0] exp_q[$];
  logic [14:0] mask_q[$];

  logic [3:0]  d [4];
  logic [3:0]  dmax [4];
  logic [3:0]  dpre [4];
  logic        set_req = 1'b0;
  logic [15:0] set_val = '0;

  clock_set_ctrl #(
    .PRESET_SU(0), .PRESET_ST(0), .PRESET_MU(PMU), .PRESET_MT(PMT), .BLINK_DIV(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .BtnMode(BtnMode), .BtnInc(BtnInc),
    .BtnClr(BtnClr), .Tco(Tco), .En(En), .Load(Load), .Valor(Valor),
    .Blank(Blank), .Mode(Mode), .CarryOut(CarryOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    dmax[0] = 4'd9; dmax[1] = 4'd5; dmax[2] = 4'd9; dmax[3] = 4'd5;
    dpre[0] = 4'd0; dpre[1] = 4'd0; dpre[2] = 4'(PMU); dpre[3] = 4'(PMT);
  end

  // Digit counters: Load beats Enable, each wraps at its terminal count.
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (set_req)      d[i] <= set_val[4*i +: 4];
      else if (Load[i]) d[i] <= dpre[i];
      else if (En[i])   d[i] <= (d[i] == dmax[i]) ? 4'd0 : d[i] + 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) Tco[i] = (d[i] == dmax[i]);
  end

  function automatic logic [14:0] pk(logic [3:0] en, logic [3:0] ld, logic co,
                                     logic [1:0] md, logic [3:0] bl);
    return {en, ld, co, md, bl};
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(string tag, logic [14:0] exp, logic [14:0] mask);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    mask_q.push_back(mask);
  endtask

  task automatic check_out();
    string       t;
    logic [14:0] e;
    logic [14:0] m;
    logic [14:0] o;
    n_assert++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    o = {En, Load, CarryOut, Mode, Blank};
    n_assert++;
    assert ((o & m) === (e & m)) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b mask=%b", t, o, e, m);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic set_time(logic [15:0] t);
    set_val = t;
    set_req = 1'b1;
    cyc(1);
    set_req = 1'b0;
  endtask

  task automatic press_mode(string tag, logic [1:0] from_m, logic [1:0] to_m);
    BtnMode = 1'b1;
    cyc(1); #1;
    expect_out({tag, "_press"}, pk(4'b0, 4'b0, 1'b0, from_m, 4'b0), M_NOBL);
    check_out();
    BtnMode = 1'b0;
    cyc(1); #1;
    expect_out({tag, "_after"}, pk(4'b0, 4'b0, 1'b0, to_m, 4'b0), M_ALL);
    check_out();
  endtask

  task automatic press_inc(string tag, logic [3:0] exp_en, logic [1:0] md);
    BtnInc = 1'b1;
    cyc(1); #1;
    expect_out(tag, pk(exp_en, 4'b0, 1'b0, md, 4'b0), M_NOBL);
    check_out();
    BtnInc = 1'b0;
    cyc(1); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; Tick = 1'b0; BtnMode = 1'b0; BtnInc = 1'b0; BtnClr = 1'b0;
    set_time(16'h0000);
    cyc(2);
    Rst = 1'b0;
    #1;
    expect_out("reset", pk(4'b0, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();
    chk("valor", Valor, 16'h1200);

    // Rollover 59:58 -> 59:59 -> 00:00 with one carry pulse
    set_time(16'h5958);
    Tick = 1'b1; #1;
    expect_out("tick1", pk(4'b0001, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();
    cyc(1); Tick = 1'b0; #1;
    chk("time_5959", {d[3], d[2], d[1], d[0]}, 16'h5959);
    expect_out("idle_5959", pk(4'b0, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();
    Tick = 1'b1; #1;
    expect_out("tick2_roll", pk(4'b1111, 4'b0, 1'b1, 2'b00, 4'b0), M_ALL);
    check_out();
    cyc(1); Tick = 1'b0; #1;
    chk("time_0000", {d[3], d[2], d[1], d[0]}, 16'h0000);
    expect_out("carry_once", pk(4'b0, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();

    // Mode cycling, first press held for 100 cycles
    BtnMode = 1'b1;
    cyc(1); #1;
    expect_out("m1_press", pk(4'b0, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();
    cyc(1); #1;
    expect_out("m1_after", pk(4'b0, 4'b0, 1'b0, 2'b01, 4'b0), M_ALL);
    check_out();
    cyc(98);
    expect_out("m1_held", pk(4'b0, 4'b0, 1'b0, 2'b01, 4'b0), M_MODE);
    check_out();
    BtnMode = 1'b0;
    cyc(2);
    press_mode("m2", 2'b01, 2'b10);
    cyc(1);
    press_mode("m3", 2'b10, 2'b00);
    cyc(1);

    // Minute setting with wrap, ticks ignored
    set_time(16'h5830);
    press_mode("to_min", 2'b00, 2'b01);
    Tick = 1'b1;
    press_inc("inc1", 4'b0100, 2'b01);
    Tick = 1'b0;
    chk("time_5930", {d[3], d[2], d[1], d[0]}, 16'h5930);
    press_inc("inc2_wrap", 4'b1100, 2'b01);
    chk("time_0030", {d[3], d[2], d[1], d[0]}, 16'h0030);
    press_inc("inc3", 4'b0100, 2'b01);
    chk("time_0130", {d[3], d[2], d[1], d[0]}, 16'h0130);
    Tick = 1'b1; #1;
    expect_out("tick_in_set", pk(4'b0, 4'b0, 1'b0, 2'b01, 4'b0), M_NOBL);
    check_out();
    cyc(1); Tick = 1'b0; #1;
    chk("secs_held", {d[3], d[2], d[1], d[0]}, 16'h0130);

    // Clear and increment together: clear wins
    BtnClr = 1'b1; BtnInc = 1'b1;
    cyc(1); #1;
    expect_out("clr_inc", pk(4'b0000, 4'b1100, 1'b0, 2'b01, 4'b0), M_NOBL);
    check_out();
    BtnClr = 1'b0; BtnInc = 1'b0;
    cyc(1); #1;
    chk("time_1230", {d[3], d[2], d[1], d[0]}, 16'h1230);
    chk("valor_min", {8'h00, Valor[15:8]}, 16'h0012);

    // Mode and increment together: mode wins, then blink in SET_SEC
    BtnMode = 1'b1; BtnInc = 1'b1;
    cyc(1); #1;
    expect_out("mode_inc", pk(4'b0, 4'b0, 1'b0, 2'b01, 4'b0), M_NOBL);
    check_out();
    BtnMode = 1'b0; BtnInc = 1'b0;
    cyc(1); #1;
    for (int i = 0; i < 12; i++) begin
      expect_out($sformatf("blink%0d", i),
                 pk(4'b0, 4'b0, 1'b0, 2'b10, ((i / 4) % 2 == 1) ? 4'b0011 : 4'b0000), M_ALL);
      check_out();
      cyc(1); #1;
    end
    chk("time_1230_b", {d[3], d[2], d[1], d[0]}, 16'h1230);
    press_mode("to_run", 2'b10, 2'b00);
    cyc(1);

    // Reset mid SET_SEC with increment held
    press_mode("r_min", 2'b00, 2'b01);
    cyc(1);
    press_mode("r_sec", 2'b01, 2'b10);
    BtnInc = 1'b1;
    cyc(1); #1;
    expect_out("sec_inc", pk(4'b0001, 4'b0, 1'b0, 2'b10, 4'b0), M_NOBL);
    check_out();
    cyc(1);
    Rst = 1'b1; #1;
    expect_out("in_rst", pk(4'b0, 4'b0, 1'b0, 2'b00, 4'b0), M_STRB);
    check_out();
    cyc(1);
    Rst = 1'b0; #1;
    expect_out("post_rst", pk(4'b0, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();
    cyc(3); #1;
    expect_out("inc_held", pk(4'b0, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();
    Tick = 1'b1; #1;
    expect_out("tick_after_rst", pk(4'b0001, 4'b0, 1'b0, 2'b00, 4'b0), M_ALL);
    check_out();
    cyc(1); Tick = 1'b0; BtnInc = 1'b0; #1;
    chk("time_1232", {d[3], d[2], d[1], d[0]}, 16'h1232);

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
